dds_ch_scheduler: RTL

- Time-multiplexed N-channel DDS controller that shares one synchronous 4096x14 sine ROM among NCH phase accumulators.
- Owns per-channel config (phase increment, phase offset, enable), round-robin slot sequencing, ROM address generation and sample tagging.
- Sits between the config/control bus and the shared sine ROM; downstream consumers demux samples by smp_ch.

---
 rtl/dds_ch_scheduler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dds_ch_scheduler.sv
// dds_ch_scheduler: time-multiplexed NCH-channel DDS sharing one sine ROM.
// Ports: clk/rst_n (sync, active-low); cfg_* config write with
//   cfg_ready handshake; sync_all clears all accumulators; rom_addr/rom_data
//   talk to a 1-cycle synchronous ROM; smp_* tagged samples; frame_tick
//   marks slot NCH-1 leaving the pipeline.
module dds_ch_scheduler #(
  parameter int NCH = 4,
  parameter int CHW = 2,
  parameter int PW  = 12,
  parameter int DW  = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [PW-1:0]  cfg_inc,
  input  logic [PW-1:0]  cfg_ofs,
  input  logic           cfg_en,
  input  logic           sync_all,
  output logic [PW-1:0]  rom_addr,
  input  logic [DW-1:0]  rom_data,
  output logic           smp_valid,
  output logic [CHW-1:0] smp_ch,
  output logic [DW-1:0]  smp_data,
  output logic           frame_tick
);

  localparam logic [CHW-1:0] LAST = CHW'(NCH - 1);

  logic [CHW-1:0] slot;
  logic [PW-1:0]  acc [NCH];
  logic [PW-1:0]  inc [NCH];
  logic [PW-1:0]  ofs [NCH];
  logic [NCH-1:0] en;

  logic           v1;
  logic           v2;
  logic [CHW-1:0] t1;
  logic [CHW-1:0] t2;

  logic           cfg_we;
  logic           svc_en;

  // The channel being serviced is never writable, so stage 0
  // always sees a stable inc/ofs/en for its slot.
  assign cfg_ready = (cfg_ch != slot);
  assign cfg_we    = cfg_valid && cfg_ready;
  assign svc_en    = en[slot];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (slot == LAST) begin
      slot <= '0;
    end else begin
      slot <= slot + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en <= '0;
      for (int i = 0; i < NCH; i++) begin
        inc[i] <= '0;
        ofs[i] <= '0;
      end
    end else if (cfg_we) begin
      en[cfg_ch]  <= cfg_en;
      inc[cfg_ch] <= cfg_inc;
      ofs[cfg_ch] <= cfg_ofs;
    end
  end

  // sync_all beats both the enable-rising clear and accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (sync_all) begin
          acc[i] <= '0;
        end else if (cfg_we && cfg_ch == CHW'(i)
                     && cfg_en && !en[i]) begin
          acc[i] <= '0;
        end else if (slot == CHW'(i) && en[i]) begin
          acc[i] <= acc[i] + inc[i];
        end
      end
    end
  end

  // Stage 0: address issue uses the pre-clear accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rom_addr <= '0;
      v1       <= 1'b0;
      t1       <= '0;
    end else begin
      if (svc_en) begin
        rom_addr <= acc[slot] + ofs[slot];
      end
      v1 <= svc_en;
      t1 <= slot;
    end
  end

  // Stage 1: ROM latches rom_addr on this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      t2 <= '0;
    end else begin
      v2 <= v1;
      t2 <= t1;
    end
  end

  // Stage 2: frame_tick follows the tag even for idle slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_valid  <= 1'b0;
      smp_ch     <= '0;
      smp_data   <= '0;
      frame_tick <= 1'b0;
    end else begin
      smp_valid  <= v2;
      smp_ch     <= t2;
      smp_data   <= rom_data;
      frame_tick <= (t2 == LAST);
    end
  end

endmodule
